// File: rtl/dacsched_pkg.sv
// dacsched_pkg: shared state encoding and sizing constants for the DAC scheduler
package dacsched_pkg;
    localparam int NREQ_MAX = 8;
    localparam int IDXW     = 3;
    typedef enum logic [2:0] {IDLE, ARM, WAITLO, BUSY, DONE, GAP} state_t;
endpackage

// File: rtl/dacsched_rrarb.sv
// dacsched_rrarb: combinational rotating-priority picker, searching upward from ptr+1 with wrap
module dacsched_rrarb
    import dacsched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] reqv,
    input  logic [IDXW-1:0] ptr,
    output logic            valid,
    output logic [IDXW-1:0] idx
);
    logic [NREQ-1:0] rot;
    // rotate so bit 0 is the requester just after ptr, then take the lowest set bit
    always_comb begin
        rot   = NREQ'({reqv, reqv} >> (int'(ptr) + 1));
        valid = |reqv;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (rot[k]) idx = IDXW'((int'(ptr) + 1 + k) % NREQ);
    end
endmodule

// File: rtl/dacsched.sv
// dacsched: round-robin scheduler sharing one serial DAC transmitter among NREQ requesters
// Optional transmitter-acknowledge watchdog and sticky daterr are built when DACSCHED_TIMEOUT_EN is defined.
module dacsched
    import dacsched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int GAPCYC  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              dacclk,
    input  logic              dacrstn,
    input  logic [NREQ-1:0]   reqv,
    input  logic [8*NREQ-1:0] reqcmd,
    input  logic [8*NREQ-1:0] reqdata,
    output logic [NREQ-1:0]   reqack,
    output logic              dacdav,
    output logic [7:0]        daccmd,
    output logic [7:0]        dacdata,
    input  logic              davdac,
    output logic              busy,
    output logic [IDXW-1:0]   gntidx,
    output logic              daterr
);
    localparam int GW = (GAPCYC > 1) ? $clog2(GAPCYC) : 1;

    state_t          state, nxt;
    logic [IDXW-1:0] ptr, arb_idx;
    logic            arb_v, abort;
    logic [GW-1:0]   gapcnt;
    logic [7:0]      selcmd, seldata;

    if (NREQ < 2 || NREQ > NREQ_MAX || GAPCYC < 1 || TIMEOUT < 1) begin : g_badparam
        $error("dacsched: parameter out of range");
    end

    dacsched_rrarb #(.NREQ(NREQ)) u_arb (
        .reqv  (reqv),
        .ptr   (ptr),
        .valid (arb_v),
        .idx   (arb_idx)
    );

    // mux out the command/data bytes of the requester the arbiter is offering
    always_comb begin
        selcmd  = '0;
        seldata = '0;
        for (int i = 0; i < NREQ; i++)
            if (arb_idx == IDXW'(i)) begin
                selcmd  = reqcmd[8*i +: 8];
                seldata = reqdata[8*i +: 8];
            end
    end

`ifdef DACSCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmocnt;
    // watchdog counts cycles spent waiting on the transmitter; cleared outside WAITLO/BUSY
    always_ff @(posedge dacclk or negedge dacrstn)
        if (!dacrstn) tmocnt <= '0;
        else tmocnt <= (state == WAITLO || state == BUSY) ? tmocnt + 1'b1 : '0;
    assign abort = (state == WAITLO || state == BUSY) && tmocnt == TW'(TIMEOUT - 1);
    // timeout flag stays set until reset
    always_ff @(posedge dacclk or negedge dacrstn)
        if (!dacrstn) daterr <= 1'b0;
        else daterr <= daterr | abort;
`else
    assign abort  = 1'b0;
    assign daterr = 1'b0;
`endif

    // state register; reset drops dacdav immediately because dacdav decodes state
    always_ff @(posedge dacclk or negedge dacrstn)
        if (!dacrstn) state <= IDLE;
        else state <= nxt;

    // next state plus transmitter and requester handshake outputs
    always_comb begin
        dacdav = state == ARM || state == WAITLO || state == BUSY;
        busy   = state != IDLE;
        reqack = (state == DONE) ? NREQ'(1) << gntidx : '0;
        nxt    = state;
        case (state)
            IDLE:    nxt = arb_v ? ARM : IDLE;
            ARM:     nxt = WAITLO;
            WAITLO:  nxt = davdac ? WAITLO : BUSY;
            BUSY:    nxt = davdac ? DONE : BUSY;
            DONE:    nxt = GAP;
            GAP:     nxt = (gapcnt == '0) ? IDLE : GAP;
            default: nxt = IDLE;
        endcase
        if (abort) nxt = GAP;
    end

    // grant capture, round-robin pointer and inter-word gap counter
    always_ff @(posedge dacclk or negedge dacrstn)
        if (!dacrstn) begin
            daccmd  <= '0;
            dacdata <= '0;
            gntidx  <= '0;
            ptr     <= '0;
            gapcnt  <= '0;
        end else begin
            if (state == IDLE && arb_v) begin
                daccmd  <= selcmd;
                dacdata <= seldata;
                gntidx  <= arb_idx;
            end
            if (state == DONE || abort) ptr <= gntidx;
            gapcnt <= (state == GAP) ? gapcnt - 1'b1 : GW'(GAPCYC - 1);
        end
endmodule

// File: tb/tb_dacsched.sv
// tb_dacsched: randomized self-checking bench for dacsched with a behavioural transmitter and arbiter model
`timescale 1ns/1ps
module tb_dacsched;
    localparam int NREQ    = 4;
    localparam int GAPCYC  = 2;
    localparam int TIMEOUT = 64;

    logic              dacclk = 0;
    logic              dacrstn = 0;
    logic [NREQ-1:0]   reqv = '0;
    logic [8*NREQ-1:0] reqcmd = '0;
    logic [8*NREQ-1:0] reqdata = '0;
    logic [NREQ-1:0]   reqack;
    logic              dacdav;
    logic [7:0]        daccmd, dacdata;
    logic              davdac = 0;
    logic              busy;
    logic [2:0]        gntidx;
    logic              daterr;

    int checks = 0, failures = 0;
    int xlen = 34, stale_n = 0;
    bit noack = 0;
    int xcnt = 0, hi_run = 0, low_run = 0, last_hi = 0, min_low = 1000, cyc = 0;
    bit prev_dav = 0, seen_hi = 0;
    int m_ptr = 0;

    dacsched #(.NREQ(NREQ), .GAPCYC(GAPCYC), .TIMEOUT(TIMEOUT)) dut (
        .dacclk  (dacclk),
        .dacrstn (dacrstn),
        .reqv    (reqv),
        .reqcmd  (reqcmd),
        .reqdata (reqdata),
        .reqack  (reqack),
        .dacdav  (dacdav),
        .daccmd  (daccmd),
        .dacdata (dacdata),
        .davdac  (davdac),
        .busy    (busy),
        .gntidx  (gntidx),
        .daterr  (daterr)
    );

    always #5 dacclk = ~dacclk;

    // transmitter model and dacdav run-length recorder, sampled 2ns after each rising edge
    initial forever begin
        @(posedge dacclk);
        #2;
        cyc++;
        if (dacdav) begin
            if (!prev_dav && seen_hi && low_run < min_low) min_low = low_run;
            hi_run++;
            low_run = 0;
            seen_hi = 1;
            xcnt++;
            if (xcnt > stale_n) davdac = !noack && xcnt >= xlen;
        end else begin
            if (prev_dav) last_hi = hi_run;
            hi_run = 0;
            low_run++;
            xcnt = 0;
            if (stale_n == 0) davdac = 0;
        end
        prev_dav = dacdav;
    end

    initial begin
        #1000000;
        $display("watchdog expired at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // round-robin rule: first requester set, searching from ptr+1 upward with wrap
    function automatic int pick(input logic [NREQ-1:0] m, input int p);
        for (int k = 1; k <= NREQ; k++)
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic wait_ack(input int budget, output bit got);
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge dacclk);
            got = (reqack != 0);
        end
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 100 && busy !== 0; i++) @(negedge dacclk);
    endtask

    task automatic test_reset;
        dacrstn = 0;
        repeat (3) @(negedge dacclk);
        checks++;
        if ({reqack, dacdav, daccmd, dacdata, busy, gntidx, daterr} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got ack=%b dav=%b cmd=%h data=%h busy=%b gnt=%0d err=%b exp all zero",
                     reqack, dacdav, daccmd, dacdata, busy, gntidx, daterr);
        end
        dacrstn = 1;
        m_ptr = 0;
        repeat (2) @(negedge dacclk);
        checks++;
        if (busy !== 0 || dacdav !== 0) begin
            failures++;
            $display("FAIL idle_no_req got busy=%b dav=%b exp 0 0", busy, dacdav);
        end
    endtask

    task automatic test_single;
        bit got;
        int n;
        xlen = 34;
        reqcmd[7:0] = 8'h30;
        reqdata[7:0] = 8'hA5;
        reqv = 4'b0001;
        repeat (3) @(negedge dacclk);
        checks++;
        if (!(dacdav === 1 && daccmd === 8'h30 && dacdata === 8'hA5 && busy === 1 && gntidx === 3'd0)) begin
            failures++;
            $display("FAIL single_xfer got dav=%b cmd=%h data=%h busy=%b gnt=%0d exp 1 30 a5 1 0",
                     dacdav, daccmd, dacdata, busy, gntidx);
        end
        wait_ack(200, got);
        reqv = 0;
        checks++;
        if (!got || reqack !== 4'b0001) begin
            failures++;
            $display("FAIL single_ack got=%b exp=0001", reqack);
        end
        checks++;
        if (last_hi !== xlen) begin
            failures++;
            $display("FAIL single_dav_len got=%0d exp=%0d", last_hi, xlen);
        end
        m_ptr = 0;
        @(negedge dacclk);
        checks++;
        if (reqack !== 0 || dacdav !== 0) begin
            failures++;
            $display("FAIL single_ack_pulse got ack=%b dav=%b exp 0 0", reqack, dacdav);
        end
        n = 1;
        while (busy === 1 && n < 20) begin
            @(negedge dacclk);
            n++;
        end
        checks++;
        if (n !== GAPCYC + 1) begin
            failures++;
            $display("FAIL single_gap got=%0d exp=%0d", n, GAPCYC + 1);
        end
    endtask

    task automatic test_round_robin;
        bit got;
        int exp, prev_cyc;
        logic [7:0] ec, ed;
        logic [NREQ-1:0] m;
        xlen = $urandom_range(6, 20);
        for (int i = 0; i < NREQ; i++) begin
            reqcmd[8*i +: 8] = 8'($urandom);
            reqdata[8*i +: 8] = 8'($urandom);
        end
        reqv = '1;
        min_low = 1000;
        prev_cyc = -1;
        for (int t = 0; t < 16; t++) begin
            exp = pick(reqv, m_ptr);
            ec = reqcmd[8*exp +: 8];
            ed = reqdata[8*exp +: 8];
            wait_ack(200, got);
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL rr_timeout t=%0d got no ack exp ack for %0d", t, exp);
                break;
            end
            checks++;
            if (reqack !== NREQ'(1) << exp || gntidx !== 3'(exp)) begin
                failures++;
                $display("FAIL rr_grant t=%0d got ack=%b gnt=%0d exp idx=%0d", t, reqack, gntidx, exp);
            end
            checks++;
            if (daccmd !== ec || dacdata !== ed) begin
                failures++;
                $display("FAIL rr_word t=%0d got %h/%h exp %h/%h", t, daccmd, dacdata, ec, ed);
            end
            if (prev_cyc >= 0) begin
                checks++;
                if (cyc - prev_cyc !== xlen + GAPCYC + 2) begin
                    failures++;
                    $display("FAIL rr_period t=%0d got=%0d exp=%0d", t, cyc - prev_cyc, xlen + GAPCYC + 2);
                end
            end
            prev_cyc = cyc;
            m_ptr = exp;
            reqcmd[8*exp +: 8] = 8'($urandom);
            reqdata[8*exp +: 8] = 8'($urandom);
            if (t >= 4) begin
                m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
                reqv = m;
            end
        end
        checks++;
        if (min_low < GAPCYC + 2) begin
            failures++;
            $display("FAIL rr_min_gap got=%0d exp>=%0d", min_low, GAPCYC + 2);
        end
        reqv = 0;
        wait_idle();
    endtask

    task automatic test_stale;
        bit got;
        int exp;
        for (int s = 1; s <= 3; s += 2) begin
            stale_n = s;
            xlen = $urandom_range(s + 3, 24);
            reqcmd[15:8] = 8'($urandom);
            reqdata[15:8] = 8'($urandom);
            reqv = 4'b0010;
            for (int w = 0; w < 2; w++) begin
                exp = pick(reqv, m_ptr);
                wait_ack(200, got);
                checks++;
                if (!got || reqack !== NREQ'(1) << exp || last_hi !== xlen) begin
                    failures++;
                    $display("FAIL stale_ack s=%0d w=%0d got ack=%b hi=%0d exp ack idx %0d hi=%0d",
                             s, w, reqack, last_hi, exp, xlen);
                end
                m_ptr = exp;
            end
            reqv = 0;
            stale_n = 0;
            wait_idle();
        end
    endtask

    task automatic test_hold_data;
        bit got;
        xlen = 12;
        reqcmd[23:16] = 8'h5C;
        reqdata[23:16] = 8'h11;
        reqv = 4'b0100;
        for (int i = 0; i < 20 && !(busy === 1 && gntidx === 3'd2); i++) @(negedge dacclk);
        reqcmd[23:16] = 8'hC5;
        reqdata[23:16] = 8'h22;
        wait_ack(100, got);
        reqv = 0;
        checks++;
        if (!got || reqack !== 4'b0100 || dacdata !== 8'h11 || daccmd !== 8'h5C) begin
            failures++;
            $display("FAIL hold_data got ack=%b cmd=%h data=%h exp 0100 5c 11", reqack, daccmd, dacdata);
        end
        m_ptr = 2;
        wait_idle();
    endtask

    task automatic test_reset_mid;
        bit got;
        int exp;
        xlen = 34;
        reqcmd[31:24] = 8'($urandom);
        reqdata[31:24] = 8'($urandom);
        reqv = 4'b1001;
        for (int i = 0; i < 20 && dacdav !== 1; i++) @(negedge dacclk);
        repeat (9) @(negedge dacclk);
        #1 dacrstn = 0;
        #1;
        checks++;
        if (dacdav !== 0) begin
            failures++;
            $display("FAIL rst_async_dav got=%b exp=0", dacdav);
        end
        repeat (2) @(negedge dacclk);
        checks++;
        if ({reqack, busy, gntidx, daccmd, dacdata, daterr} !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs got ack=%b busy=%b gnt=%0d cmd=%h data=%h err=%b exp all zero",
                     reqack, busy, gntidx, daccmd, dacdata, daterr);
        end
        dacrstn = 1;
        m_ptr = 0;
        exp = pick(reqv, m_ptr);
        wait_ack(200, got);
        checks++;
        if (!got || reqack !== NREQ'(1) << exp || last_hi !== xlen ||
            daccmd !== reqcmd[8*exp +: 8] || dacdata !== reqdata[8*exp +: 8]) begin
            failures++;
            $display("FAIL rst_restart got ack=%b hi=%0d cmd=%h data=%h exp idx=%0d hi=%0d",
                     reqack, last_hi, daccmd, dacdata, exp, xlen);
        end
        m_ptr = exp;
        reqv = 0;
        wait_idle();
    endtask

`ifdef DACSCHED_TIMEOUT_EN
    task automatic test_timeout;
        bit got;
        int e1, e2, hi, acks;
        noack = 1;
        reqcmd[15:0] = 16'($urandom);
        reqv = 4'b0011;
        e1 = pick(reqv, m_ptr);
        for (int i = 0; i < 20 && dacdav !== 1; i++) @(negedge dacclk);
        hi = 0;
        acks = 0;
        while (dacdav === 1 && hi < TIMEOUT + 20) begin
            @(negedge dacclk);
            hi++;
            if (reqack !== 0) acks++;
        end
        checks++;
        if (hi < TIMEOUT || hi > TIMEOUT + 2 || acks !== 0 || daterr !== 1) begin
            failures++;
            $display("FAIL timeout_abort got hi=%0d acks=%0d err=%b exp hi~%0d acks=0 err=1", hi, acks, daterr, TIMEOUT);
        end
        noack = 0;
        xlen = 10;
        e2 = pick(reqv, e1);
        wait_ack(200, got);
        reqv = 0;
        checks++;
        if (!got || reqack !== NREQ'(1) << e2) begin
            failures++;
            $display("FAIL timeout_next got ack=%b exp idx=%0d", reqack, e2);
        end
        m_ptr = e2;
        wait_idle();
    endtask
`endif

    initial begin
        bit exp_err;
        exp_err = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_stale();
        test_hold_data();
        test_reset_mid();
`ifdef DACSCHED_TIMEOUT_EN
        test_timeout();
        exp_err = 1;
`endif
        checks++;
        if (daterr !== exp_err) begin
            failures++;
            $display("FAIL final_daterr got=%b exp=%b", daterr, exp_err);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
